shr_frame_capture: RTL and testbench
====================================

SHR_FRAME_CAPTURE -- requirements
Module: shr_frame_capture

Interface
REQ-001 Parameter FRAME_BITS, default 644: serial frame length in bits, equal to the width of the JTAG data register.
REQ-002 Parameter CNT_W, default 10: width of the bit counter, which shall satisfy 2**CNT_W > FRAME_BITS.
REQ-003 Port clk_in, input, 1 bit: the single clock; all logic is in this domain, and its frequency shall be at least 4x the sclk_in frequency.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port sclk_in, input, 1 bit: serial shift clock from the DIN/SYNC driver; asynchronous to clk_in.
REQ-006 Port din_in, input, 1 bit: serial data, valid at the sclk_in rising edge.
REQ-007 Port syn_in, input, 1 bit: frame sync, active-low; a frame spans syn_in low.
REQ-008 Port expected_in, input, FRAME_BITS bits: reference frame for comparison.
REQ-009 Port frame_out, output, FRAME_BITS bits: last captured frame.
REQ-010 Port frame_valid, output, 1 bit: one-cycle pulse at frame end.
REQ-011 Port bit_count, output, CNT_W bits: number of bits captured in the current or last frame.
REQ-012 Port len_err, output, 1 bit: last frame length differed from FRAME_BITS.
REQ-013 Port match, output, 1 bit: last frame equals expected_in and len_err is clear.
REQ-014 Port busy, output, 1 bit: high while in SHIFT.
REQ-015 Port frame_cnt, output, 8 bits: count of completed frames, wrapping at 255 -> 0.

Function
REQ-016 sclk_in, din_in and syn_in shall each pass through a 2-flop synchronizer; din_in shall be delayed so that it is sampled with the same latency as sclk_in.
REQ-017 The FSM shall have three states, IDLE, SHIFT and DONE: IDLE goes to SHIFT on a synchronized syn falling edge; SHIFT goes to DONE on a synchronized syn rising edge; DONE goes to IDLE unconditionally after one cycle.
REQ-018 On entering SHIFT, bit_count shall clear to 0 and the shift register shall clear to all zeros.
REQ-019 In SHIFT, each synchronized sclk rising edge shall shift the synchronized din into bit 0 while existing bits move toward the MSB; the first bit received ends at frame_out[FRAME_BITS-1].
REQ-020 bit_count shall increment per captured edge and saturate at FRAME_BITS+1.
REQ-021 Edges beyond FRAME_BITS shall not shift.
REQ-022 An sclk rising edge in the same cycle as a syn rising edge shall be captured before the frame ends.
REQ-023 In DONE, frame_out, len_err (bit_count != FRAME_BITS) and match shall update, frame_valid shall pulse high for exactly 1 cycle, and frame_cnt shall increment.
REQ-024 frame_out, len_err and match shall hold their values until the next DONE.
REQ-025 sclk edges in IDLE shall be ignored.
REQ-026 A frame with zero edges shall produce len_err=1, match=0 and bit_count=0.
REQ-027 Latency from the syn_in rising edge to the frame_valid pulse shall be at most 4 clk_in cycles (2 synchronizer cycles, edge detect, and DONE).

Reset
REQ-028 On reset: FSM to IDLE; frame_out to 0; bit_count to 0; frame_cnt to 0; frame_valid, len_err, match and busy to 0.
REQ-029 On reset: syn synchronizer stages to 1 (inactive); sclk and din synchronizer stages to 0.
REQ-030 Reset asserted mid-frame shall abort the frame without a frame_valid pulse.
REQ-031 If syn_in is already low when reset releases, no capture shall start until a fresh syn falling edge is seen.

Structure
REQ-032 Shared package shr_pkg shall hold the FRAME_BITS default, the CNT_W default and the FSM state type (IDLE/SHIFT/DONE).
REQ-033 Sub-module sync_edge shall provide the 2-flop synchronizer plus registered rise/fall detect, with reset value set by parameter; it shall be instantiated for sclk and syn.
REQ-034 din shall use an equivalent-delay synchronizer without edge detect.

Verification
REQ-035 Scenario: 644-bit frame equal to expected_in, with sclk = clk_in/8 -> frame_valid pulses once, bit_count=644, len_err=0, match=1, frame_cnt=1.
REQ-036 Scenario: 644-bit frame with bit 0 of expected flipped -> match=0, len_err=0, and frame_out shows the flipped bit.
REQ-037 Scenario: 643-bit frame, then a 646-bit frame -> first gives bit_count=643 and len_err=1; second gives bit_count=645 (saturated), len_err=1, and frame_out holds the first 644 bits.
REQ-038 Scenario: rst pulsed after 300 bits -> no frame_valid and all outputs 0; with syn held low after reset release -> no capture until syn rises and falls again.
REQ-039 Scenario: sclk and syn rising edges in the same clk_in cycle on the 644th bit -> bit captured, bit_count=644, len_err=0.
REQ-040 Scenario: 256 back-to-back short frames -> frame_cnt wraps to 0, with exactly one frame_valid per frame.

Source files
------------

// File: rtl/shr_pkg.sv
// shr_pkg: shared defaults and FSM state type for the serial frame capture block
package shr_pkg;

   localparam int FRAME_BITS_DEF = 644;
   localparam int CNT_W_DEF      = 10;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

endpackage

// File: rtl/shr_frame_capture_sync_edge.sv
// sync_edge: 2-flop synchronizer with registered rise/fall detect and selectable reset level
module sync_edge #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o,
   output logic rise_o,
   output logic fall_o
);

   logic s1_q, s2_q, s3_q, rise_q, fall_q;

   // synchronize, keep one cycle of history, and register the edge pulses
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_q   <= RST_VAL;
         s2_q   <= RST_VAL;
         s3_q   <= RST_VAL;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         s1_q   <= d_i;
         s2_q   <= s1_q;
         s3_q   <= s2_q;
         rise_q <= s2_q & ~s3_q;
         fall_q <= ~s2_q & s3_q;
      end
   end

   assign q_o    = s2_q;
   assign rise_o = rise_q;
   assign fall_o = fall_q;

endmodule

// File: rtl/shr_frame_capture.sv
// shr_frame_capture: capture a SYNC-framed serial word from an async DIN/SCLK pair and compare it to a reference
module shr_frame_capture
   import shr_pkg::*;
#(
   parameter int FRAME_BITS = FRAME_BITS_DEF,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic                  clk_in,
   input  logic                  rst,
   input  logic                  sclk_in,
   input  logic                  din_in,
   input  logic                  syn_in,
   input  logic [FRAME_BITS-1:0] expected_in,
   output logic [FRAME_BITS-1:0] frame_out,
   output logic                  frame_valid,
   output logic [CNT_W-1:0]      bit_count,
   output logic                  len_err,
   output logic                  match,
   output logic                  busy,
   output logic [7:0]            frame_cnt
);

   localparam logic [CNT_W-1:0] FULL = CNT_W'(FRAME_BITS);
   localparam logic [CNT_W-1:0] SAT  = CNT_W'(FRAME_BITS + 1);

   state_t                state_q, state_d;
   logic                  sclk_rise, sclk_lvl_unused, sclk_fall_unused;
   logic                  syn_lvl, syn_rise, syn_fall;
   logic                  din_s1_q, din_s2_q, din_s3_q;
   logic [1:0]            prime_q, prime_d;
   logic                  armed_q, armed_d;
   logic [FRAME_BITS-1:0] sh_q, sh_d, frame_q, frame_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  len_q, len_d, match_q, match_d;
   logic [7:0]            fcnt_q, fcnt_d;
   logic                  enter, take, fin;

   sync_edge #(.RST_VAL(1'b0)) u_sclk (
      .clk_i  (clk_in),
      .rst_i  (rst),
      .d_i    (sclk_in),
      .q_o    (sclk_lvl_unused),
      .rise_o (sclk_rise),
      .fall_o (sclk_fall_unused)
   );

   sync_edge #(.RST_VAL(1'b1)) u_syn (
      .clk_i  (clk_in),
      .rst_i  (rst),
      .d_i    (syn_in),
      .q_o    (syn_lvl),
      .rise_o (syn_rise),
      .fall_o (syn_fall)
   );

   // din delay line: two synchronizer stages plus one to line up with the registered sclk edge
   always_ff @(posedge clk_in) begin
      if (rst) {din_s1_q, din_s2_q, din_s3_q} <= '0;
      else     {din_s1_q, din_s2_q, din_s3_q} <= {din_in, din_s1_q, din_s2_q};
   end

   // next state: a syn fall only starts a frame once syn has been genuinely seen high after reset
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = (syn_fall && armed_q) ? SHIFT : IDLE;
         SHIFT:   state_d = syn_rise ? DONE : SHIFT;
         default: state_d = IDLE;
      endcase
   end

   // datapath next values; a capture coinciding with the syn rise lands in the published frame
   always_comb begin
      enter   = (state_q == IDLE) && (state_d == SHIFT);
      take    = (state_q == SHIFT) && sclk_rise;
      fin     = (state_q == SHIFT) && syn_rise;
      prime_d = (prime_q == 2'd2) ? prime_q : prime_q + 2'd1;
      armed_d = armed_q | ((prime_q == 2'd2) && syn_lvl);
      sh_d    = enter ? '0 : (take && cnt_q < FULL) ? {sh_q[FRAME_BITS-2:0], din_s3_q} : sh_q;
      cnt_d   = enter ? '0 : (take && cnt_q != SAT) ? cnt_q + CNT_W'(1) : cnt_q;
      frame_d = fin ? sh_d : frame_q;
      len_d   = fin ? (cnt_d != FULL) : len_q;
      match_d = fin ? ((cnt_d == FULL) && (sh_d == expected_in)) : match_q;
      fcnt_d  = fin ? fcnt_q + 8'd1 : fcnt_q;
   end

   // state and datapath registers
   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_q <= IDLE;
         prime_q <= '0;
         armed_q <= 1'b0;
         sh_q    <= '0;
         cnt_q   <= '0;
         frame_q <= '0;
         len_q   <= 1'b0;
         match_q <= 1'b0;
         fcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         prime_q <= prime_d;
         armed_q <= armed_d;
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
         frame_q <= frame_d;
         len_q   <= len_d;
         match_q <= match_d;
         fcnt_q  <= fcnt_d;
      end
   end

   assign frame_out   = frame_q;
   assign frame_valid = (state_q == DONE);
   assign bit_count   = cnt_q;
   assign len_err     = len_q;
   assign match       = match_q;
   assign busy        = (state_q == SHIFT);
   assign frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_shr_frame_capture.sv
// tb_shr_frame_capture: table-driven and directed checks of shr_frame_capture against a bit-list frame model
module tb_shr_frame_capture;

   localparam int FB = 644;
   localparam int CW = 10;

   logic          clk_in = 1'b0;
   logic          rst, sclk_in, din_in, syn_in;
   logic [FB-1:0] expected_in, frame_out;
   logic          frame_valid, len_err, match, busy;
   logic [CW-1:0] bit_count;
   logic [7:0]    frame_cnt;

   int total = 0, bad = 0, vcount = 0, exp_fc = 0;
   bit tx [FB+8];

   typedef struct {
      int nbits;
      int emode;
      int cnt;
      bit len;
      bit mt;
   } vec_t;
   vec_t vt [7];

   shr_frame_capture #(.FRAME_BITS(FB), .CNT_W(CW)) dut (
      .clk_in      (clk_in),
      .rst         (rst),
      .sclk_in     (sclk_in),
      .din_in      (din_in),
      .syn_in      (syn_in),
      .expected_in (expected_in),
      .frame_out   (frame_out),
      .frame_valid (frame_valid),
      .bit_count   (bit_count),
      .len_err     (len_err),
      .match       (match),
      .busy        (busy),
      .frame_cnt   (frame_cnt)
   );

   always #5 clk_in = ~clk_in;

   // count every cycle frame_valid is seen high
   always @(negedge clk_in) if (frame_valid) vcount++;

   task automatic chk(input string tag, input string nm, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s/%s: got %0d want %0d", tag, nm, act, exp);
      end
   endtask

   task automatic chkf(input string tag, input string nm, input logic [FB-1:0] act, input logic [FB-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s/%s: got %0h want %0h", tag, nm, act, exp);
      end
   endtask

   // first received bit sits at the top of the captured bits; only the first FB bits are kept
   function automatic logic [FB-1:0] model_frame(input int n);
      logic [FB-1:0] f;
      int k;
      f = '0;
      k = (n > FB) ? FB : n;
      for (int i = 0; i < k; i++) f[k-1-i] = tx[i];
      return f;
   endfunction

   task automatic send_bit(input bit b);
      din_in  = b;
      sclk_in = 1'b0;
      repeat (4) @(negedge clk_in);
      sclk_in = 1'b1;
      repeat (4) @(negedge clk_in);
   endtask

   task automatic do_frame(input string tag, input int n, input int emode, input bit same_edge,
                           input int ecnt, input bit elen, input bit emt);
      logic [FB-1:0] mf, ev;
      int v0, lat;
      bit got;
      for (int i = 0; i < n; i++) tx[i] = 1'($urandom_range(0, 1));
      mf = model_frame(n);
      for (int i = 0; i < FB; i++) ev[i] = 1'($urandom_range(0, 1));
      if (emode == 0) ev = mf;
      else if (emode == 1) ev = mf ^ FB'(1);
      expected_in = ev;
      syn_in  = 1'b1;
      sclk_in = 1'b0;
      repeat (6) @(negedge clk_in);
      v0 = vcount;
      syn_in = 1'b0;
      repeat (8) @(negedge clk_in);
      for (int i = 0; i < n; i++) begin
         if (same_edge && i == n - 1) begin
            din_in  = tx[i];
            sclk_in = 1'b0;
            repeat (4) @(negedge clk_in);
            sclk_in = 1'b1;
            syn_in  = 1'b1;
         end else send_bit(tx[i]);
      end
      if (!(same_edge && n > 0)) begin
         sclk_in = 1'b0;
         repeat (4) @(negedge clk_in);
         syn_in = 1'b1;
      end
      got = 0;
      lat = 0;
      for (int l = 1; l <= 8 && !got; l++) begin
         @(negedge clk_in);
         if (frame_valid) begin
            got = 1;
            lat = l;
         end
      end
      chk(tag, "valid_within_4", int'(got && lat <= 4), 1);
      if (got) begin
         exp_fc = (exp_fc + 1) % 256;
         chk(tag, "bit_count", int'(bit_count), ecnt);
         chk(tag, "len_err", int'(len_err), int'(elen));
         chk(tag, "match", int'(match), int'(emt));
         chk(tag, "frame_cnt", int'(frame_cnt), exp_fc);
         chkf(tag, "frame_out", frame_out, mf);
      end
      @(negedge clk_in);
      chk(tag, "valid_one_cycle", int'(frame_valid), 0);
      sclk_in = 1'b0;
      repeat (4) @(negedge clk_in);
      chk(tag, "valid_pulses", vcount - v0, 1);
      chkf(tag, "frame_hold", frame_out, mf);
      chk(tag, "match_hold", int'(match), int'(emt));
   endtask

   initial begin
      vt[0] = '{644, 0, 644, 1'b0, 1'b1};
      vt[1] = '{644, 1, 644, 1'b0, 1'b0};
      vt[2] = '{643, 0, 643, 1'b1, 1'b0};
      vt[3] = '{646, 0, 645, 1'b1, 1'b0};
      vt[4] = '{0,   0, 0,   1'b1, 1'b0};
      vt[5] = '{1,   2, 1,   1'b1, 1'b0};
      vt[6] = '{645, 0, 645, 1'b1, 1'b0};

      rst = 1'b1;
      sclk_in = 1'b0;
      din_in = 1'b0;
      syn_in = 1'b1;
      expected_in = '0;
      repeat (3) @(negedge clk_in);
      chk("reset", "frame_valid", int'(frame_valid), 0);
      chk("reset", "busy", int'(busy), 0);
      chk("reset", "bit_count", int'(bit_count), 0);
      chk("reset", "frame_cnt", int'(frame_cnt), 0);
      chk("reset", "len_match", int'({len_err, match}), 0);
      chkf("reset", "frame_out", frame_out, '0);
      rst = 1'b0;

      for (int v = 0; v < 7; v++)
         do_frame($sformatf("vec%0d", v), vt[v].nbits, vt[v].emode, 1'b0, vt[v].cnt, vt[v].len, vt[v].mt);

      do_frame("same_edge", 644, 0, 1'b1, 644, 1'b0, 1'b1);

      begin : mid_reset
         int v0;
         v0 = vcount;
         syn_in = 1'b0;
         repeat (8) @(negedge clk_in);
         for (int i = 0; i < 300; i++) send_bit(1'($urandom_range(0, 1)));
         chk("midrst", "busy_before", int'(busy), 1);
         rst = 1'b1;
         repeat (3) @(negedge clk_in);
         rst = 1'b0;
         sclk_in = 1'b0;
         exp_fc = 0;
         repeat (2) @(negedge clk_in);
         chk("midrst", "busy", int'(busy), 0);
         chk("midrst", "bit_count", int'(bit_count), 0);
         chk("midrst", "frame_cnt", int'(frame_cnt), 0);
         chk("midrst", "len_match", int'({len_err, match}), 0);
         chkf("midrst", "frame_out", frame_out, '0);
         for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(0, 1)));
         sclk_in = 1'b0;
         repeat (6) @(negedge clk_in);
         chk("syn_low", "busy", int'(busy), 0);
         chk("syn_low", "bit_count", int'(bit_count), 0);
         syn_in = 1'b1;
         repeat (10) @(negedge clk_in);
         chk("syn_low", "no_valid", vcount - v0, 0);
      end
      do_frame("after_rst", 5, 0, 1'b0, 5, 1'b1, 1'b0);

      begin : wrap
         int v0;
         rst = 1'b1;
         repeat (3) @(negedge clk_in);
         rst = 1'b0;
         exp_fc = 0;
         v0 = vcount;
         for (int f = 0; f < 256; f++) do_frame("wrap", 1, 2, 1'b0, 1, 1'b1, 1'b0);
         chk("wrap", "frame_cnt_final", int'(frame_cnt), 0);
         chk("wrap", "total_pulses", vcount - v0, 256);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
